aoi4_self_checker: RTL

//  Synthesizable stimulus/response checker for the 4-input AND-OR-INVERT gate

---
 rtl/aoi4_self_checker.sv | 120 ++++++++++++
 1 files changed

// File: rtl/aoi4_self_checker.sv
// On-board stimulus/response checker for a 4-input AND-OR-INVERT gate.
// Walks all 16 input vectors, lets each settle, and compares y against EXPECT.
module aoi4_self_checker #(
    parameter logic [15:0] EXPECT = 16'h0777,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    // With no settle time a vector is sampled on the cycle after it is applied.
    localparam state_t LOAD_STATE = (SETTLE == 0) ? SAMPLE : WAIT;

    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic [3:0] ff_q, ff_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        // NOTE: every signal gets a hold default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    vec_d   = 4'd0;
                    err_d   = 5'd0;
                    ff_d    = 4'd0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = SETTLE_CNT;
                    state_d = LOAD_STATE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (y != EXPECT[vec_q]) begin
                    err_d = err_q + 5'd1;
                    if (err_q == 5'd0) begin
                        ff_d = vec_q;
                    end
                end
                if (vec_q == 4'd15) begin
                    // Parking the vector at 0 keeps the gate inputs low while idle.
                    vec_d   = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = SETTLE_CNT;
                    state_d = LOAD_STATE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 5'd0;
            ff_q    <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {a, b, c, d} = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_count    = err_q;
    assign first_fail   = ff_q;
    assign pass         = done_q && (err_q == 5'd0);

endmodule
